// File: rtl/microcode_sequencer_pkg.sv
// Shared opcode/addressing enums, sequencer states and control-flag bit map for the 6502-compatible core.
package cpu_pkg;

  localparam int NUMFLAGS = 40;
  typedef logic [NUMFLAGS-1:0] flags_t;

  typedef enum logic [5:0] {
    NOP  = 6'd0,  LDA  = 6'd1,  LDX  = 6'd2,  LDY  = 6'd3,
    STO  = 6'd4,  STA  = 6'd5,  STX  = 6'd6,  STY  = 6'd7,
    ADC  = 6'd8,  ASLA = 6'd9,  ROLA = 6'd10, LSRA = 6'd11,
    RORA = 6'd12, TAX  = 6'd13, TAY  = 6'd14, TYA  = 6'd15,
    BNE  = 6'd16, BEQ  = 6'd17
  } instr_t;

  typedef enum logic [4:0] {
    implied = 5'd0, A = 5'd1, IMMEDIATE = 5'd2, zp = 5'd3, zpX = 5'd4, abs = 5'd5,
    absX = 5'd6, absY = 5'd7, indX = 5'd8, indY = 5'd9, rel = 5'd10
  } addr_mode_t;

  typedef enum logic [1:0] {S_FETCH, S_ADDR, S_FIX, S_EXEC} seq_state_t;

  localparam int F_PC_INC  = 0;
  localparam int F_IR_LD   = 1;
  localparam int F_MEM_RD  = 2;
  localparam int F_MEM_WR  = 3;
  localparam int F_ADL_LD  = 4;
  localparam int F_ADH_LD  = 5;
  localparam int F_ADD_X   = 6;
  localparam int F_ADD_Y   = 7;
  localparam int F_ADH_INC = 8;
  localparam int F_PTR_LO  = 9;
  localparam int F_PTR_HI  = 10;
  localparam int F_A_LD    = 11;
  localparam int F_X_LD    = 12;
  localparam int F_Y_LD    = 13;
  localparam int F_NZ_UPD  = 14;
  localparam int F_ALU_SHL = 15;
  localparam int F_ALU_SHR = 16;
  localparam int F_ALU_ROT = 17;
  localparam int F_ST_SEL  = 18;
  localparam int F_BR_TEST = 19;
  localparam int F_BR_TAKE = 20;
  localparam int F_PC_LD   = 21;
  localparam int F_OFS_LD  = 22;
  localparam int F_SRC_Y   = 23;

  function automatic flags_t fb(input int i);
    return flags_t'(1) << i;
  endfunction

  localparam flags_t FETCH_FLAGS = fb(F_PC_INC) | fb(F_IR_LD) | fb(F_MEM_RD);
  localparam flags_t FIX_FLAGS   = fb(F_ADH_INC) | fb(F_MEM_RD);

endpackage

// File: rtl/microcode_sequencer_control_rom.sv
// Combinational control-flag tables indexed by (addressing mode, step) and (instruction, step).
module control_rom
  import cpu_pkg::*;
#(
  parameter int STEPW     = 3,
  parameter int NUM_INSTR = 64,
  parameter int NUM_ADDR  = 16
) (
  input  logic [4:0]       i_addr_code,
  input  logic [STEPW-1:0] i_addr_step,
  input  logic [5:0]       i_instr_code,
  input  logic [STEPW-1:0] i_instr_step,
  input  logic             i_br_row,
  output flags_t           o_addr_flags,
  output flags_t           o_instr_flags
);

  localparam flags_t OPR_LO = fb(F_PC_INC) | fb(F_MEM_RD) | fb(F_ADL_LD);
  localparam flags_t OPR_HI = fb(F_PC_INC) | fb(F_MEM_RD) | fb(F_ADH_LD);

  int         w_astep;
  int         w_istep;
  logic [5:0] w_key;

  always_comb begin
    o_addr_flags = '0;
    w_astep      = int'(i_addr_step);
    if (int'(i_addr_code) < NUM_ADDR) begin
      case (i_addr_code)
        zp:  if (w_astep == 0) o_addr_flags = OPR_LO;
        zpX: case (w_astep)
               0:       o_addr_flags = OPR_LO;
               1:       o_addr_flags = fb(F_ADD_X);
               default: ;
             endcase
        abs, absX, absY: case (w_astep)
               0:       o_addr_flags = OPR_LO;
               1:       o_addr_flags = OPR_HI
                                     | ((i_addr_code == absX) ? fb(F_ADD_X) : '0)
                                     | ((i_addr_code == absY) ? fb(F_ADD_Y) : '0);
               default: ;
             endcase
        indY: case (w_astep)
               0:       o_addr_flags = OPR_LO;
               1:       o_addr_flags = fb(F_MEM_RD) | fb(F_PTR_LO);
               2:       o_addr_flags = fb(F_MEM_RD) | fb(F_PTR_HI) | fb(F_ADD_Y);
               default: ;
             endcase
        rel: if (w_astep == 0) o_addr_flags = fb(F_PC_INC) | fb(F_MEM_RD) | fb(F_OFS_LD);
        default: ;
      endcase
    end
  end

  // All three stores share one table row; the register source is chosen elsewhere.
  always_comb begin
    o_instr_flags = '0;
    w_istep       = int'(i_instr_step);
    w_key         = (i_instr_code == STA || i_instr_code == STX || i_instr_code == STY)
                    ? STO : i_instr_code;
    if (int'(w_key) < NUM_INSTR) begin
      if (i_br_row) begin
        if (w_key == BNE || w_key == BEQ) o_instr_flags = fb(F_BR_TAKE) | fb(F_PC_LD);
      end else begin
        case (w_key)
          LDA: case (w_istep)
                 0:       o_instr_flags = fb(F_MEM_RD);
                 1:       o_instr_flags = fb(F_A_LD) | fb(F_NZ_UPD);
                 default: ;
               endcase
          LDX:  if (w_istep == 0) o_instr_flags = fb(F_MEM_RD) | fb(F_X_LD) | fb(F_NZ_UPD);
          LDY:  if (w_istep == 0) o_instr_flags = fb(F_MEM_RD) | fb(F_Y_LD) | fb(F_NZ_UPD);
          STO:  if (w_istep == 0) o_instr_flags = fb(F_MEM_WR) | fb(F_ST_SEL);
          ASLA: if (w_istep == 0) o_instr_flags = fb(F_ALU_SHL) | fb(F_A_LD) | fb(F_NZ_UPD);
          ROLA: if (w_istep == 0) o_instr_flags = fb(F_ALU_SHL) | fb(F_ALU_ROT) | fb(F_A_LD) | fb(F_NZ_UPD);
          LSRA: if (w_istep == 0) o_instr_flags = fb(F_ALU_SHR) | fb(F_A_LD) | fb(F_NZ_UPD);
          RORA: if (w_istep == 0) o_instr_flags = fb(F_ALU_SHR) | fb(F_ALU_ROT) | fb(F_A_LD) | fb(F_NZ_UPD);
          TYA:  if (w_istep == 0) o_instr_flags = fb(F_SRC_Y) | fb(F_A_LD) | fb(F_NZ_UPD);
          BNE, BEQ: if (w_istep == 0) o_instr_flags = fb(F_BR_TEST);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Steps FETCH -> ADDR -> optional FIX -> EXEC and drives the per-cycle control flags from the latched codes.
module microcode_sequencer
  import cpu_pkg::*;
#(
  parameter int NUMFLAGS  = cpu_pkg::NUMFLAGS,
  parameter int STEPW     = 3,
  parameter int NUM_INSTR = 64,
  parameter int NUM_ADDR  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready,
  input  logic                load,
  input  logic [5:0]          instructionCode,
  input  logic [4:0]          addressingCode,
  input  logic [2:0]          addressTimingCode,
  input  logic [2:0]          opTimingCode,
  input  logic                pageCross,
  input  logic                branchTaken,
  output logic [NUMFLAGS-1:0] outFlags,
  output logic [STEPW-1:0]    timeOut,
  output logic                isAddressing,
  output logic                sync,
  output logic                done
);

  seq_state_t       r_state, w_state_nxt;
  logic [STEPW-1:0] r_step, w_step_nxt;
  logic [5:0]       r_instr, w_instr_nxt;
  logic [4:0]       r_mode, w_mode_nxt;
  logic [2:0]       r_alen, w_alen_nxt, r_olen, w_olen_nxt, w_olen_eff;
  logic             r_brx, w_brx_nxt;
  logic             w_bypass, w_indexed, w_store, w_branch, w_addr_last, w_exec_last, w_finish;
  flags_t           w_addr_flags, w_instr_flags;

  control_rom #(.STEPW(STEPW), .NUM_INSTR(NUM_INSTR), .NUM_ADDR(NUM_ADDR)) u_rom (
    .i_addr_code   (r_mode),
    .i_addr_step   (r_step),
    .i_instr_code  (r_instr),
    .i_instr_step  (r_step),
    .i_br_row      (r_brx),
    .o_addr_flags  (w_addr_flags),
    .o_instr_flags (w_instr_flags)
  );

  assign w_bypass    = (addressingCode == IMMEDIATE) || (addressingCode == implied) ||
                       (addressingCode == A) || (addressTimingCode == 3'd0);
  assign w_indexed   = (r_mode == absX) || (r_mode == absY) || (r_mode == indY);
  assign w_store     = (r_instr == STA) || (r_instr == STX) || (r_instr == STY);
  assign w_branch    = (r_instr == BNE) || (r_instr == BEQ);
  assign w_olen_eff  = (r_olen == 3'd0) ? 3'd1 : r_olen;
  assign w_addr_last = (r_step == STEPW'(r_alen - 3'd1));
  assign w_exec_last = (r_step == STEPW'(w_olen_eff - 3'd1));
  // branchTaken is only valid on the last EXEC step, so finishing there must look at it directly.
  assign w_finish    = r_brx || (w_exec_last && !(w_branch && branchTaken));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_step  <= '0;
      r_instr <= NOP;
      r_mode  <= implied;
      r_alen  <= '0;
      r_olen  <= '0;
      r_brx   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_instr <= w_instr_nxt;
      r_mode  <= w_mode_nxt;
      r_alen  <= w_alen_nxt;
      r_olen  <= w_olen_nxt;
      r_brx   <= w_brx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_instr_nxt = r_instr;
    w_mode_nxt  = r_mode;
    w_alen_nxt  = r_alen;
    w_olen_nxt  = r_olen;
    w_brx_nxt   = r_brx;
    if (ready) begin
      case (r_state)
        S_FETCH: if (load) begin
          w_instr_nxt = instructionCode;
          w_mode_nxt  = addressingCode;
          w_alen_nxt  = addressTimingCode;
          w_olen_nxt  = opTimingCode;
          w_step_nxt  = '0;
          w_brx_nxt   = 1'b0;
          w_state_nxt = w_bypass ? S_EXEC : S_ADDR;
        end
        S_ADDR: begin
          if (w_addr_last) begin
            w_step_nxt  = '0;
            w_state_nxt = (w_indexed && (pageCross || w_store)) ? S_FIX : S_EXEC;
          end else begin
            w_step_nxt  = r_step + STEPW'(1);
          end
        end
        S_FIX: begin
          w_step_nxt  = '0;
          w_state_nxt = S_EXEC;
        end
        S_EXEC: begin
          if (w_finish) begin
            w_step_nxt  = '0;
            w_brx_nxt   = 1'b0;
            w_state_nxt = S_FETCH;
          end else begin
            w_step_nxt  = r_step + STEPW'(1);
            w_brx_nxt   = w_exec_last;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_comb begin
    outFlags = NUMFLAGS'(FETCH_FLAGS);
    case (r_state)
      S_ADDR:  outFlags = NUMFLAGS'(w_addr_flags);
      S_FIX:   outFlags = NUMFLAGS'(FIX_FLAGS);
      S_EXEC:  outFlags = NUMFLAGS'(w_instr_flags);
      default: ;
    endcase
  end

  assign timeOut      = r_step;
  assign sync         = (r_state == S_FETCH);
  assign isAddressing = (r_state == S_ADDR) || (r_state == S_FIX);
  assign done         = (r_state == S_EXEC) && w_finish;

endmodule
